// File: rtl/cpu_core_param.sv
// Parametrised multicycle CPU core with a req/ack memory port, N/Z/C/V flags,
// conditional jump and an illegal-opcode fault.
module cpu_core_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_pc,
  output logic [3:0]        o_flags
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_JUMP = 8'h02;
  localparam logic [7:0] OP_JMPZ = 8'h03;
  localparam logic [7:0] OP_MATH = 8'h04;
  localparam logic [7:0] OP_LDFM = 8'h05;
  localparam logic [7:0] OP_LDFI = 8'h06;
  localparam logic [7:0] OP_LDFR = 8'h07;
  localparam logic [7:0] OP_CPFR = 8'h08;
  localparam logic [7:0] OP_STOM = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPA, S_OPB, S_DATA, S_EXEC, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        code_q;
  logic [DATA_W-1:0] opa_q, opb_q, data_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [3:0]        flags_q;
  logic              fault_q;

  logic              xfer, illegal;
  logic [RW-1:0]     ra, rb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] math_res;
  logic              math_c, math_v;

  // Every opcode from JUMP upward carries a first operand word; loads/stores/copies carry two.
  function automatic logic needs_opa(input logic [7:0] c);
    return (c >= OP_JUMP) && (c <= OP_STOM);
  endfunction

  function automatic logic needs_opb(input logic [7:0] c);
    return (c >= OP_LDFM) && (c <= OP_STOM);
  endfunction

  function automatic logic needs_data(input logic [7:0] c);
    return (c == OP_LDFM) || (c == OP_LDFR) || (c == OP_STOM);
  endfunction

  assign ra        = opa_q[RW-1:0];
  assign rb        = opb_q[RW-1:0];
  assign xfer      = o_mem_req && i_mem_ack;
  assign illegal   = (code_q > OP_STOM) || ((code_q == OP_MATH) && (opa_q > DATA_W'(6)));
  assign data_addr = (code_q == OP_LDFR) ? regs_q[rb][ADDR_W-1:0] : opb_q[ADDR_W-1:0];
  assign sum       = {1'b0, regs_q[0]} + {1'b0, regs_q[1]};
  assign diff      = {1'b0, regs_q[0]} - {1'b0, regs_q[1]};

  always_comb begin
    math_res = '0;
    math_c   = 1'b0;
    math_v   = 1'b0;
    case (opa_q[2:0])
      3'd0: begin
        math_res = sum[DATA_W-1:0];
        math_c   = sum[DATA_W];
        math_v   = (regs_q[0][DATA_W-1] == regs_q[1][DATA_W-1]) &&
                   (math_res[DATA_W-1] != regs_q[0][DATA_W-1]);
      end
      3'd1: begin
        math_res = diff[DATA_W-1:0];
        math_c   = diff[DATA_W];
        math_v   = (regs_q[0][DATA_W-1] != regs_q[1][DATA_W-1]) &&
                   (math_res[DATA_W-1] != regs_q[0][DATA_W-1]);
      end
      3'd2: math_res = regs_q[0] & regs_q[1];
      3'd3: math_res = regs_q[0] | regs_q[1];
      3'd4: math_res = regs_q[0] ^ regs_q[1];
      3'd5: begin
        math_res = {regs_q[0][DATA_W-2:0], 1'b0};
        math_c   = regs_q[0][DATA_W-1];
      end
      3'd6: begin
        math_res = {1'b0, regs_q[0][DATA_W-1:1]};
        math_c   = regs_q[0][0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // The fetch decision looks at the incoming word so no cycle is spent decoding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (i_start) state_d = S_FETCH;
      S_FETCH: if (xfer) state_d = needs_opa(i_mem_rdata[7:0]) ? S_OPA : S_EXEC;
      S_OPA:   if (xfer) state_d = needs_opb(code_q) ? S_OPB : S_EXEC;
      S_OPB:   if (xfer) state_d = needs_data(code_q) ? S_DATA : S_EXEC;
      S_DATA:  if (xfer) state_d = S_EXEC;
      S_EXEC:  state_d = (illegal || (code_q == OP_HALT)) ? S_HALT : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = pc_q;
    o_mem_wdata = '0;
    case (state_q)
      S_FETCH, S_OPA, S_OPB: o_mem_req = 1'b1;
      S_DATA: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = data_addr;
        o_mem_we    = (code_q == OP_STOM);
        o_mem_wdata = regs_q[ra];
      end
      default: ;
    endcase
  end

  assign o_busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign o_halted = (state_q == S_HALT);
  assign o_fault  = fault_q;
  assign o_pc     = pc_q;
  assign o_flags  = flags_q;

  // Operand words are latched on their ack; all architectural updates happen in EXEC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= '0;
      code_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: if (i_start) begin
          pc_q    <= i_start_addr;
          fault_q <= 1'b0;
        end
        S_FETCH: if (xfer) begin
          code_q <= i_mem_rdata[7:0];
          pc_q   <= pc_q + ADDR_W'(1);
        end
        S_OPA: if (xfer) begin
          opa_q <= i_mem_rdata;
          pc_q  <= pc_q + ADDR_W'(1);
        end
        S_OPB: if (xfer) begin
          opb_q <= i_mem_rdata;
          pc_q  <= pc_q + ADDR_W'(1);
        end
        S_DATA: if (xfer && !o_mem_we) data_q <= i_mem_rdata;
        S_EXEC: begin
          if (illegal) fault_q <= 1'b1;
          else begin
            case (code_q)
              OP_JUMP: pc_q <= opa_q[ADDR_W-1:0];
              OP_JMPZ: if (flags_q[2]) pc_q <= opa_q[ADDR_W-1:0];
              OP_MATH: begin
                regs_q[0] <= math_res;
                flags_q   <= {math_res[DATA_W-1], math_res == '0, math_c, math_v};
              end
              OP_LDFM, OP_LDFR: regs_q[ra] <= data_q;
              OP_LDFI: regs_q[ra] <= opb_q;
              OP_CPFR: regs_q[ra] <= regs_q[rb];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: hand-computed program table, protocol corner cases,
// and random programs checked against an instruction-level reference model.
module tb_cpu_core_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] startAddr = '0;
  logic       memReq, memWe, memAck = 1'b0;
  logic [7:0] memAddr, memWdata, memRdata = '0;
  logic       busy, halted, fault;
  logic [7:0] pc;
  logic [3:0] flags;

  always #5 clk = ~clk;

  cpu_core_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_addr(startAddr),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_ack(memAck), .i_mem_rdata(memRdata),
    .o_busy(busy), .o_halted(halted), .o_fault(fault), .o_pc(pc), .o_flags(flags)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int   waitStates = 0, waitCnt = 0, xfers = 0;
  bit   pending = 0, noAck = 0, spuriousAck = 0;
  logic [7:0] heldAddr, heldWdata;
  logic heldWe;

  // Reference machine state, kept at instruction level.
  logic [7:0] mMem [256];
  logic [7:0] mRegs [8];
  logic [7:0] mPc;
  logic [3:0] mFlags;
  bit   mFault;
  int   mAcc, mInstr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Memory responder: decides ack at the negedge before the transfer edge.
  always @(negedge clk) begin
    memAck = 1'b0;
    if (memReq === 1'b1) begin
      if (pending) begin
        checkOutput("req addr stable", memAddr, heldAddr);
        checkOutput("req we stable", memWe, heldWe);
        checkOutput("req wdata stable", memWdata, heldWdata);
      end
      if (!noAck && waitCnt >= waitStates) begin
        memAck = 1'b1;
        xfers++;
        if (memWe) mem[memAddr] = memWdata;
        else       memRdata = mem[memAddr];
        waitCnt = 0;
        pending = 0;
      end else begin
        waitCnt++;
        pending   = 1;
        heldAddr  = memAddr;
        heldWe    = memWe;
        heldWdata = memWdata;
      end
    end else begin
      memAck  = spuriousAck;
      waitCnt = 0;
      pending = 0;
    end
  end

  task automatic doReset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s, output int cyc);
    int guard;
    @(negedge clk);
    start = 1'b1;
    startAddr = s;
    xfers = 0;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    guard = 0;
    while (!halted && guard < 3000) begin
      if (busy) cyc++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic modelRun(input logic [7:0] s);
    logic [7:0] code, a, b;
    int x, y, sx, sy, res;
    bit c, v, done;
    mPc = s; mFault = 0; mAcc = 0; mInstr = 0; done = 0;
    for (int step = 0; step < 500 && !done; step++) begin
      code = mMem[mPc]; mPc++; mAcc++; mInstr++;
      if (code >= 8'h02 && code <= 8'h09) begin a = mMem[mPc]; mPc++; mAcc++; end
      if (code >= 8'h05 && code <= 8'h09) begin b = mMem[mPc]; mPc++; mAcc++; end
      case (code)
        8'h00: done = 1;
        8'h01: ;
        8'h02: mPc = a;
        8'h03: if (mFlags[2]) mPc = a;
        8'h04: begin
          x = mRegs[0]; y = mRegs[1];
          sx = (x > 127) ? x - 256 : x;
          sy = (y > 127) ? y - 256 : y;
          c = 0; v = 0; res = 0;
          case (a)
            8'd0: begin res = (x + y) % 256; c = (x + y) > 255; v = (sx + sy > 127) || (sx + sy < -128); end
            8'd1: begin res = (x - y + 256) % 256; c = x < y; v = (sx - sy > 127) || (sx - sy < -128); end
            8'd2: res = x & y;
            8'd3: res = x | y;
            8'd4: res = x ^ y;
            8'd5: begin res = (x * 2) % 256; c = x > 127; end
            8'd6: begin res = x / 2; c = (x % 2) == 1; end
            default: begin mFault = 1; done = 1; end
          endcase
          if (!mFault) begin
            mRegs[0] = res[7:0];
            mFlags = {res > 127, res == 0, c, v};
          end
        end
        8'h05: begin mAcc++; mRegs[a[2:0]] = mMem[b]; end
        8'h06: mRegs[a[2:0]] = b;
        8'h07: begin mAcc++; mRegs[a[2:0]] = mMem[mRegs[b[2:0]]]; end
        8'h08: mRegs[a[2:0]] = mRegs[b[2:0]];
        8'h09: begin mAcc++; mMem[b] = mRegs[a[2:0]]; end
        default: begin mFault = 1; done = 1; end
      endcase
    end
  endtask

  // Random straight-line programs; jumps skip a filler byte so no loops form.
  task automatic genProgram();
    int p, n, kind;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    p = 0;
    n = $urandom_range(5, 15);
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0: begin mem[p] = 8'h01; p += 1; end
        1: begin mem[p] = 8'h02; mem[p+1] = 8'(p + 3); mem[p+2] = 8'hFF; p += 3; end
        2: begin mem[p] = 8'h03; mem[p+1] = 8'(p + 3); mem[p+2] = 8'h01; p += 3; end
        3: begin mem[p] = 8'h04; mem[p+1] = 8'($urandom_range(0, 6)); p += 2; end
        8: begin
          mem[p] = 8'h09; mem[p+1] = 8'($urandom_range(0, 255));
          mem[p+2] = 8'h80 | 8'($urandom_range(0, 127)); p += 3;
        end
        default: begin
          mem[p] = 8'(kind + 1); mem[p+1] = 8'($urandom_range(0, 255));
          mem[p+2] = 8'($urandom_range(0, 255)); p += 3;
        end
      endcase
    end
    mem[p] = 8'h00;
    for (int i = 0; i < 256; i++) mMem[i] = mem[i];
  endtask

  typedef struct {
    string        name;
    logic [7:0]   start;
    int           waitSt;
    int           len;
    logic [191:0] prog;
    logic [7:0]   expPc;
    logic [3:0]   expFlags;
    logic         expFault;
    logic [7:0]   chkAddr;
    logic [7:0]   chkVal;
    int           expCycles;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic [7:0] s, input int w, input int l,
                        input logic [191:0] p, input logic [7:0] epc, input logic [3:0] ef,
                        input logic efa, input logic [7:0] ca, input logic [7:0] cv, input int ec);
    vec_t v;
    v.name = n; v.start = s; v.waitSt = w; v.len = l; v.prog = p; v.expPc = epc;
    v.expFlags = ef; v.expFault = efa; v.chkAddr = ca; v.chkVal = cv; v.expCycles = ec;
    vecs.push_back(v);
  endtask

  task automatic loadProg(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    for (int i = 0; i < v.len; i++) mem[8'(v.start + i)] = v.prog[8*(v.len-1-i) +: 8];
  endtask

  initial begin
    int cyc, guard, diffs;
    logic [7:0] pcHold;

    addVec("ldfi_stom", 8'h00, 0, 7, 'h06012A0901F000, 8'h07, 4'h0, 0, 8'hF0, 8'h2A, 11);
    addVec("add_ovf", 8'h00, 0, 12, 'h06007F06010104000900F100, 8'h0C, 4'h9, 0, 8'hF1, 8'h80, 18);
    addVec("sub_zero", 8'h00, 0, 12, 'h06000506010504010900F200, 8'h0C, 4'h4, 0, 8'hF2, 8'h00, 18);
    addVec("stom_ldfm_w3", 8'h00, 3, 13, 'h06025A0902F00503F00903F300, 8'h0D, 4'h0, 0, 8'hF3, 8'h5A, 69);
    addVec("jmpz_taken", 8'h00, 0, 23, 'h060003060103040103100000000000000604770904F400,
           8'h17, 4'h4, 0, 8'hF4, 8'h77, 25);
    addVec("jmpz_fall", 8'h00, 0, 9, 'h03100604550904F400, 8'h09, 4'h0, 0, 8'hF4, 8'h55, 14);
    addVec("pc_wrap", 8'hFE, 0, 7, 'h0601660901F500, 8'h05, 4'h0, 0, 8'hF5, 8'h66, 11);
    addVec("illegal_3c", 8'h00, 0, 8, 'h0600113C0900F600, 8'h04, 4'h0, 1, 8'hF6, 8'hEE, 6);
    addVec("math_op7", 8'h00, 0, 2, 'h0407, 8'h02, 4'h0, 1, 8'hF0, 8'hEE, 3);
    addVec("shl_carry", 8'h00, 0, 9, 'h06008104050900F700, 8'h09, 4'h2, 0, 8'hF7, 8'h02, 14);
    addVec("shr_zero", 8'h00, 0, 6, 'h060001040600, 8'h06, 4'h6, 0, 8'hF0, 8'hEE, 9);
    addVec("ldfr_sub_w1", 8'h00, 1, 18, 'h0602F80703020800030601FF04010900F900,
           8'h12, 4'hA, 0, 8'hF9, 8'hEF, 47);

    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    checkOutput("reset req", memReq, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset fault", fault, 0);
    checkOutput("reset pc", pc, 0);
    checkOutput("reset flags", flags, 0);

    foreach (vecs[i]) begin
      doReset();
      loadProg(vecs[i]);
      waitStates = vecs[i].waitSt;
      applyStimulus(vecs[i].start, cyc);
      checkOutput({vecs[i].name, " halted"}, halted, 1);
      checkOutput({vecs[i].name, " pc"}, pc, vecs[i].expPc);
      checkOutput({vecs[i].name, " flags"}, flags, vecs[i].expFlags);
      checkOutput({vecs[i].name, " fault"}, fault, vecs[i].expFault);
      checkOutput({vecs[i].name, " mem"}, mem[vecs[i].chkAddr], vecs[i].chkVal);
      checkOutput({vecs[i].name, " cycles"}, cyc, vecs[i].expCycles);
    end

    // i_start while busy must not redirect the running program.
    doReset();
    loadProg(vecs[0]);
    waitStates = 2;
    @(negedge clk) begin start = 1'b1; startAddr = 8'h00; end
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    startAddr = 8'h40;
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (!halted && guard < 3000) begin guard++; @(negedge clk); end
    checkOutput("busy start halted", halted, 1);
    checkOutput("busy start pc", pc, 8'h07);
    checkOutput("busy start fault", fault, 0);
    checkOutput("busy start mem", mem[8'hF0], 8'h2A);

    // Ack with no request outstanding is ignored.
    pcHold = pc;
    spuriousAck = 1;
    repeat (3) @(negedge clk);
    spuriousAck = 0;
    checkOutput("spurious ack halted", halted, 1);
    checkOutput("spurious ack busy", busy, 0);
    checkOutput("spurious ack pc", pc, pcHold);

    // Reset during a stalled request.
    doReset();
    vecs[0].start = 8'h10;
    loadProg(vecs[0]);
    noAck = 1;
    @(negedge clk) begin start = 1'b1; startAddr = 8'h10; end
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (!memReq && guard < 50) begin guard++; @(negedge clk); end
    checkOutput("stall req up", memReq, 1);
    checkOutput("stall pc", pc, 8'h10);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset req", memReq, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset halted", halted, 0);
    checkOutput("mid reset pc", pc, 0);
    reset = 1'b0;
    noAck = 0;

    // Random programs against the reference model; state carries across starts.
    doReset();
    for (int i = 0; i < 8; i++) mRegs[i] = '0;
    mFlags = '0;
    for (int t = 0; t < 25; t++) begin
      waitStates = $urandom_range(0, 3);
      genProgram();
      modelRun(8'h00);
      applyStimulus(8'h00, cyc);
      diffs = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== mMem[a]) diffs++;
      checkOutput("rand halted", halted, 1);
      checkOutput("rand pc", pc, mPc);
      checkOutput("rand flags", flags, mFlags);
      checkOutput("rand fault", fault, mFault);
      checkOutput("rand transfers", xfers, mAcc);
      checkOutput("rand cycles", cyc, mAcc * (waitStates + 1) + mInstr);
      checkOutput("rand mem diffs", diffs, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
